if_fetch: RTL
=============

# if_fetch

Instruction fetch unit that supplies the `if_pc`/`if_inst` pair to the IF/ID pipeline register. It generates the fetch PC, runs a request/acknowledge handshake with instruction memory, buffers returned words in a 2-entry FIFO, and honours ID-stage stalls and branch redirects. It sits between the instruction memory port and the `if_id` latch.

## Interface
- `ADDR_W`, 32, instruction address width; matches `` `Inst_Addr ``.
- `DATA_W`, 32, instruction word width; matches `` `Inst_Data ``.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; word-aligned.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset (`` `Rst_Enable ``).
- `stall_i`  input  1  downstream hold; the head entry is not consumed.
- `branch_flag_i`  input  1  redirect request from ID.
- `branch_target_i`  input  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_req_o`  output  1  memory request valid.
- `imem_addr_o`  output  ADDR_W  request address.
- `imem_ack_i`  input  1  memory accepts the request and returns data in the same cycle.
- `imem_rdata_i`  input  DATA_W  instruction word; valid only when `imem_ack_i` is high.
- `if_pc`  output  ADDR_W  PC of the head instruction.
- `if_inst`  output  DATA_W  head instruction word.
- `if_valid`  output  1  head entry is valid.

## Operation
- **Fetch PC.**
  - Register `fpc` holds the next address to request.
  - `fpc` advances by 4 on each accepted (`imem_ack_i`) non-killed request.
  - Wrap: 32'hFFFF_FFFC goes to 32'h0000_0000 with no flag.
- **Handshake.**
  - At most one request is outstanding.
  - Once `imem_req_o` rises, `imem_req_o` and `imem_addr_o` stay constant until the cycle in which `imem_ack_i` is high. A request is never withdrawn.
  - `imem_ack_i` while `imem_req_o` is low is ignored.
- **FIFO.**
  - 2 entries, each holding {pc, inst}.
  - Push: ack on a non-killed request.
  - Pop: `if_valid && !stall_i && !branch_flag_i`.
  - Push and pop in the same cycle leave the occupancy unchanged.
- **Request issue.** `imem_req_o` for the next cycle is asserted iff the post-update occupancy is < 2, or a request is still unacked.
- **FSM.**
  - FETCH: request active, result kept.
    - ack and next occupancy < 2: stay in FETCH, address = `fpc`+4.
    - ack and next occupancy = 2: go to HOLD.
  - HOLD: no request. Go to FETCH when the occupancy drops below 2.
  - KILL: request active, result discarded. On ack, go to FETCH at the latched redirect target.
- **Redirect** (`branch_flag_i` high). Redirect has priority over stall, push and pop.
  - The FIFO is cleared at the edge.
  - `fpc` is set to `{branch_target_i[ADDR_W-1:2],2'b00}`.
  - No request outstanding, or ack in this same cycle: the ack data is dropped and the next state is FETCH at the target.
  - Request outstanding and unacked: the next state is KILL, holding the old address. The target is latched.
  - A second redirect while in KILL replaces the latched target.
- **Outputs.**
  - When `if_valid` = 1: `if_pc`/`if_inst` are the head entry.
  - When `if_valid` = 0: `if_pc` = 0 and `if_inst` = 0 (bubble).

## Timing
- **Reset values:**
  - `imem_req_o` = 0
  - `imem_addr_o` = `RESET_PC`
  - `if_valid` = 0
  - `if_pc` = 0
  - `if_inst` = 0
  - FIFO empty, state FETCH, `fpc` = `RESET_PC`
- Reset mid-operation drops any outstanding request and clears the FIFO in that cycle.
- **First request.** `imem_req_o` = 1 with `imem_addr_o` = `RESET_PC` in the first cycle after `rst` deasserts.
- **Latency.** Ack at edge N gives `if_valid` = 1 with that word in cycle N+1.
- **Throughput.** With zero-wait ack and no stall: one instruction per cycle, continuous request, occupancy 1.
- **Stall.** Occupancy fills to 2 and `imem_req_o` drops the cycle after the second push. The request resumes the cycle after the first pop.
- **Redirect.** `if_valid` = 0 the cycle after `branch_flag_i`. The first target instruction appears at the earliest 2 cycles after the redirect edge, with zero-wait memory and no outstanding request.

## Test plan
- **Reset and zero-wait stream.** Release `rst`, hold `imem_ack_i` = 1, rdata = address XOR 32'hA5A5_A5A5 → `imem_addr_o` sequence 0, 4, 8, …; `if_pc` = 0 then 4, 8 on consecutive cycles with matching `if_inst`; `if_valid` continuous from cycle 2.
- **Stall.** Hold `stall_i` = 1 for 5 cycles mid-stream at `if_pc` = 8 → `if_pc` stays 8; occupancy reaches 2; `imem_req_o` = 0 while full; after release `if_pc` continues 12, 16 with no gap or duplicate.
- **Wait-state memory.** Ack every third cycle → `imem_addr_o` stable for 3 cycles per request; `if_valid` pulses once per ack; PCs are sequential.
- **Redirect with request outstanding.** Req at 0x20 unacked, `branch_flag_i` = 1 with target 0x103 → KILL; address 0x20 held until ack; that word is never output; next request is 0x100; first valid `if_pc` = 0x100.
- **Redirect with stall and simultaneous ack.** `branch_flag_i`, `stall_i` and `imem_ack_i` all high in one cycle with target 0x40 → FIFO cleared; acked word dropped; `if_valid` = 0 next cycle; next request 0x40.
- **Wrap and reset mid-op.** `RESET_PC` = 32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert `rst` while a request is outstanding → all outputs at reset values next cycle.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch unit: drives the fetch PC and the imem request/ack handshake, and buffers
// returned words in a 2-entry FIFO that feeds the IF/ID latch. Handles stalls and redirects.
module if_fetch #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid
);

  typedef enum logic [1:0] {StFetch, StHold, StKill} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_mem_q [2];
  logic [ADDR_W-1:0] pc_mem_d [2];
  logic [DATA_W-1:0] inst_mem_q [2];
  logic [DATA_W-1:0] inst_mem_d [2];

  logic ack;
  logic pending;
  logic push;
  logic pop;
  logic unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target_i[1:0];
  assign ack             = req_q & imem_ack_i;
  assign pending         = req_q & ~imem_ack_i;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fpc_d      = fpc_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (branch_flag_i) begin
      // While in KILL, fpc_q doubles as the latched redirect target.
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      fpc_d    = {branch_target_i[ADDR_W-1:2], 2'b00};
      req_d    = 1'b1;
      if (pending) begin
        state_d = StKill;
        addr_d  = addr_q;
      end else begin
        state_d = StFetch;
        addr_d  = fpc_d;
      end
    end else begin
      push = ack & (state_q != StKill);
      pop  = if_valid & ~stall_i;
      if (push) begin
        pc_mem_d[wr_ptr_q]   = addr_q;
        inst_mem_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d             = ~wr_ptr_q;
        fpc_d                = fpc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d  = cnt_q + 2'(push) - 2'(pop);
      req_d  = pending | (cnt_d < 2'd2);
      addr_d = pending ? addr_q : fpc_d;
      if (state_q == StKill && pending) begin
        state_d = StKill;
      end else begin
        state_d = req_d ? StFetch : StHold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fpc_q    <= RESET_PC;
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      fpc_q    <= fpc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid    = (cnt_q != 2'd0);
  assign if_pc       = if_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign if_inst     = if_valid ? inst_mem_q[rd_ptr_q] : '0;

endmodule
